// File: rtl/ras_unit_pkg.sv
// Types local to the return-address stack: the per-cycle operation decoded
// from clr/push/pop and the current occupancy.
package ras_unit_pkg;

  typedef enum logic [2:0] {
    OpIdle,
    OpPush,
    OpPushFull,
    OpPop,
    OpPopEmpty,
    OpTail,
    OpFlush
  } ras_op_e;

endpackage

// File: rtl/wisc_pkg.sv
// Datapath-wide constants shared across the WISC-SC15 core.
// RAS overflow policies and the PC-source encoding for return targets.
`ifndef PC_SRC_RAS
`define PC_SRC_RAS 3'b100
`endif

package wisc_pkg;

  localparam int unsigned RAS_OVF_DROP = 0;
  localparam int unsigned RAS_OVF_WRAP = 1;

endpackage

// File: rtl/ras_unit_if.sv
// Request/status bundle between the fetch/PC logic and the return-address stack.
interface ras_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 8
);

  logic                         clr;
  logic                         push;
  logic [ADDR_W-1:0]            push_addr;
  logic                         pop;
  logic [ADDR_W-1:0]            top;
  logic                         empty;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         ovf;
  logic                         unf;

  modport master (
    output clr, push, push_addr, pop,
    input  top, empty, full, count, ovf, unf
  );

  modport slave (
    input  clr, push, push_addr, pop,
    output top, empty, full, count, ovf, unf
  );

endinterface

// File: rtl/ras_ptr_mod.sv
// Modulo-DEPTH neighbours of a stack pointer; explicit wrap compares keep
// non-power-of-two depths correct.
module ras_ptr_mod #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] ptr_inc_o,
  output logic [PTR_W-1:0] ptr_dec_o,
  output logic [PTR_W-1:0] ptr_dec2_o
);

  localparam logic [PTR_W-1:0] LastIdx  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] Last2Idx = PTR_W'(DEPTH - 2);

  always_comb begin
    ptr_inc_o = (ptr_i == LastIdx) ? '0 : ptr_i + 1'b1;
    ptr_dec_o = (ptr_i == '0) ? LastIdx : ptr_i - 1'b1;

    if (ptr_i == '0) begin
      ptr_dec2_o = Last2Idx;
    end else if (ptr_i == PTR_W'(1)) begin
      ptr_dec2_o = LastIdx;
    end else begin
      ptr_dec2_o = ptr_i - PTR_W'(2);
    end
  end

endmodule

// File: rtl/ras_unit.sv
// Hardware return-address stack: circular buffer with a registered top-of-stack
// so RET can take its target in the same cycle it is decoded.
module ras_unit
  import wisc_pkg::*;
  import ras_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = RAS_OVF_DROP
) (
  input  logic       clk,
  input  logic       rst,
  ras_unit_if.slave  ras_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]   wp_q, wp_d;
  logic [PtrW-1:0]   wp_inc, wp_dec, wp_dec2;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [PtrW-1:0]   mem_waddr;
  logic              is_empty, is_full;
  ras_op_e           op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntFull);

  ras_ptr_mod #(
    .DEPTH (DEPTH),
    .PTR_W (PtrW)
  ) u_ptr (
    .ptr_i      (wp_q),
    .ptr_inc_o  (wp_inc),
    .ptr_dec_o  (wp_dec),
    .ptr_dec2_o (wp_dec2)
  );

  // A push+pop on an empty stack is just a push, so unf stays clear.
  always_comb begin
    op = OpIdle;
    if (ras_io.clr) begin
      op = OpFlush;
    end else if (ras_io.push && ras_io.pop) begin
      op = is_empty ? OpPush : OpTail;
    end else if (ras_io.push) begin
      op = is_full ? OpPushFull : OpPush;
    end else if (ras_io.pop) begin
      op = is_empty ? OpPopEmpty : OpPop;
    end
  end

  always_comb begin
    wp_d      = wp_q;
    count_d   = count_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = wp_q;

    unique case (op)
      OpFlush: begin
        wp_d    = '0;
        count_d = '0;
        top_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      OpPush: begin
        mem_we  = 1'b1;
        wp_d    = wp_inc;
        count_d = count_q + 1'b1;
        top_d   = ras_io.push_addr;
      end
      OpPushFull: begin
        ovf_d = 1'b1;
        if (OVF_MODE == RAS_OVF_WRAP) begin
          // Writing at wp overwrites the oldest entry; count stays at DEPTH.
          mem_we = 1'b1;
          wp_d   = wp_inc;
          top_d  = ras_io.push_addr;
        end
      end
      OpPop: begin
        wp_d    = wp_dec;
        count_d = count_q - 1'b1;
        top_d   = (count_q > CntW'(1)) ? mem_q[wp_dec2] : '0;
      end
      OpPopEmpty: begin
        unf_d = 1'b1;
      end
      OpTail: begin
        mem_we    = 1'b1;
        mem_waddr = wp_dec;
        top_d     = ras_io.push_addr;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= ras_io.push_addr;
    end
  end

  assign ras_io.top   = top_q;
  assign ras_io.count = count_q;
  assign ras_io.empty = is_empty;
  assign ras_io.full  = is_full;
  assign ras_io.ovf   = ovf_q;
  assign ras_io.unf   = unf_q;

endmodule
